latch_arbiter: RTL

Round-robin arbiter that shares one `WIDTH`-bit holding register between `REQS` requesters. Each cycle it selects at most one requesting port, steers that port's data into the shared register and reports the owner a cycle later. A requester may lock the grant for up to `MAX_HOLD` consecutive cycles. The block sits in front of a shared Latch/Mux datapath pair, replacing hand-wired `sel`/`write_en` logic when more than one producer writes the same register.

---
 rtl/latch_arbiter_if.sv | 26 ++
 rtl/latch_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/latch_arbiter_if.sv
// rtl/latch_arbiter_if.sv - requester/shared-register bundle for latch_arbiter
interface latch_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int REQS  = 4
);
    localparam int OW = $clog2(REQS);

    logic [REQS-1:0]       req;
    logic [REQS-1:0]       lock;
    logic [REQS*WIDTH-1:0] in;
    logic [REQS-1:0]       grant;
    logic                  busy;
    logic [WIDTH-1:0]      out;
    logic                  out_valid;
    logic [OW-1:0]         out_owner;

    modport master (
        output req, lock, in,
        input  grant, busy, out, out_valid, out_owner
    );

    modport slave (
        input  req, lock, in,
        output grant, busy, out, out_valid, out_owner
    );
endinterface

// File: rtl/latch_arbiter.sv
// rtl/latch_arbiter.sv - round-robin arbiter with bounded lock steering one shared register
module latch_arbiter #(
    parameter int WIDTH    = 32,
    parameter int REQS     = 4,
    parameter int MAX_HOLD = 4
) (
    input logic          clk,
    input logic          reset,
    latch_arbiter_if.slave bus
);
    localparam int OW = $clog2(REQS);
    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e           state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [OW-1:0]    out_owner_q, out_owner_d;

    logic             found;
    logic [OW-1:0]    g;
    logic [CW-1:0]    cnt_new;
    logic [WIDTH-1:0] in_arr [REQS];

    for (genvar p = 0; p < REQS; p++) begin : g_unpack
        assign in_arr[p] = bus.in[p*WIDTH +: WIDTH];
    end

    // Held owner keeps priority only while it still requests; otherwise scan from ptr.
    always_comb begin
        int            j;
        logic [OW-1:0] idx;
        found = 1'b0;
        g     = '0;
        j     = 0;
        idx   = '0;
        if (state_q == HOLD && bus.req[owner_q]) begin
            found = 1'b1;
            g     = owner_q;
        end else begin
            for (int k = 0; k < REQS; k++) begin
                j = int'(ptr_q) + k;
                if (j >= REQS) j = j - REQS;
                idx = OW'(j);
                if (!found && bus.req[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < REQS; i++) begin
            bus.grant[i] = found && !reset && (g == OW'(i));
        end
    end

    always_comb begin
        state_d     = IDLE;
        owner_d     = owner_q;
        cnt_d       = '0;
        ptr_d       = ptr_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        out_owner_d = out_owner_q;
        cnt_new     = CW'(1);
        if (found) begin
            out_d       = in_arr[g];
            out_owner_d = g;
            out_valid_d = 1'b1;
            ptr_d       = (g == OW'(REQS - 1)) ? '0 : g + OW'(1);
            if (state_q == HOLD && g == owner_q) cnt_new = cnt_q + CW'(1);
            if (bus.lock[g] && int'(cnt_new) < MAX_HOLD) begin
                state_d = HOLD;
                owner_d = g;
                cnt_d   = cnt_new;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            cnt_q       <= '0;
            ptr_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_owner_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_owner_q <= out_owner_d;
        end
    end

    assign bus.busy      = (state_q == HOLD);
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_owner = out_owner_q;
endmodule
